// File: rtl/controle_pedido_if.sv
// controle_pedido_if: coin/selection/brewer handshake bundle of the order front end
interface controle_pedido_if #(parameter int CRED_W = 4);
  logic              moeda_valida;
  logic [1:0]        moeda_valor;
  logic              sel_valida;
  logic [1:0]        sel_tipo;
  logic              cancelar;
  logic              pronto;
  logic [1:0]        tipo;
  logic              rst_cafeteira;
  logic [CRED_W-1:0] credito;
  logic [CRED_W-1:0] troco;
  logic              troco_valido;
  logic              ocupado;
  logic              entregue;
  logic              erro;
  modport master (
    output moeda_valida, moeda_valor, sel_valida, sel_tipo, cancelar, pronto,
    input  tipo, rst_cafeteira, credito, troco, troco_valido, ocupado, entregue, erro
  );
  modport slave (
    input  moeda_valida, moeda_valor, sel_valida, sel_tipo, cancelar, pronto,
    output tipo, rst_cafeteira, credito, troco, troco_valido, ocupado, entregue, erro
  );
endinterface

// File: rtl/controle_pedido.sv
// controle_pedido: coin credit, drink selection and change front end for the coffee brewer
module controle_pedido #(
  parameter int CRED_W      = 4,
  parameter int MAX_CRED    = 15,
  parameter int PRECO_CURTO = 2,
  parameter int PRECO_LONGO = 3,
  parameter int PRECO_LEITE = 4,
  parameter int TIMEOUT     = 16
) (
  input logic               clock,
  input logic               reset,
  controle_pedido_if.slave  bus
);
  localparam int W  = CRED_W + 2;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {OCIOSO, PREPARO, TROCO} estado_t;
  estado_t       estado;
  logic [TW-1:0] timer;
  logic [W-1:0]  v, cred, eff, preco_sel, preco_cur, resto;
  logic          cabe, rejeita;
  function automatic logic [W-1:0] preco(input logic [1:0] t);
    return t == 2'b00 ? W'(PRECO_CURTO) : t == 2'b01 ? W'(PRECO_LONGO) :
           t == 2'b10 ? W'(PRECO_LEITE) : '0;
  endfunction
  function automatic logic [CRED_W-1:0] sat(input logic [W-1:0] s);
    return s > W'(2**CRED_W - 1) ? '1 : s[CRED_W-1:0];
  endfunction
  // coin value, effective credit (coin counted only if it fits) and price checks
  always_comb begin
    v         = bus.moeda_valida ? W'(1) << bus.moeda_valor : '0;
    cred      = W'(bus.credito);
    cabe      = (cred + v) <= W'(MAX_CRED);
    eff       = cabe ? cred + v : cred;
    preco_sel = preco(bus.sel_tipo);
    preco_cur = preco(bus.tipo);
    resto     = eff - preco_sel;
    rejeita   = bus.sel_tipo == 2'b11 || eff < preco_sel;
  end
  // order FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clock) begin
    if (reset) begin
      estado            <= OCIOSO;
      timer             <= '0;
      bus.credito       <= '0;
      bus.troco         <= '0;
      bus.troco_valido  <= 1'b0;
      bus.erro          <= 1'b0;
      bus.entregue      <= 1'b0;
      bus.tipo          <= 2'b00;
      bus.rst_cafeteira <= 1'b1;
      bus.ocupado       <= 1'b0;
    end else begin
      bus.troco_valido <= 1'b0;
      bus.erro         <= 1'b0;
      bus.entregue     <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (bus.cancelar) begin
            bus.troco        <= sat(cred + v);
            bus.troco_valido <= (cred + v) != '0;
            bus.credito      <= '0;
          end else begin
            if (v != '0 && !cabe) begin
              bus.troco        <= v[CRED_W-1:0];
              bus.troco_valido <= 1'b1;
              bus.erro         <= 1'b1;
            end
            if (bus.sel_valida && rejeita) begin
              bus.erro    <= 1'b1;
              bus.credito <= eff[CRED_W-1:0];
            end else if (bus.sel_valida) begin
              bus.tipo          <= bus.sel_tipo;
              bus.credito       <= resto[CRED_W-1:0];
              bus.rst_cafeteira <= 1'b0;
              bus.ocupado       <= 1'b1;
              timer             <= '0;
              estado            <= PREPARO;
            end else begin
              bus.credito <= eff[CRED_W-1:0];
            end
          end
        end
        PREPARO: begin
          timer <= timer + 1'b1;
          if (v != '0) begin
            bus.troco        <= v[CRED_W-1:0];
            bus.troco_valido <= 1'b1;
            bus.erro         <= 1'b1;
          end
          if (bus.pronto) begin
            bus.rst_cafeteira <= 1'b1;
            estado            <= TROCO;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            bus.troco         <= sat(cred + preco_cur + v);
            bus.troco_valido  <= 1'b1;
            bus.erro          <= 1'b1;
            bus.credito       <= '0;
            bus.rst_cafeteira <= 1'b1;
            bus.ocupado       <= 1'b0;
            estado            <= OCIOSO;
          end
        end
        default: begin
          bus.troco        <= sat(cred + v);
          bus.troco_valido <= (cred + v) != '0;
          bus.entregue     <= 1'b1;
          bus.credito      <= '0;
          bus.ocupado      <= 1'b0;
          estado           <= OCIOSO;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_controle_pedido.sv
// tb_controle_pedido: directed scenarios plus random traffic against a behavioural order model
module tb_controle_pedido;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  controle_pedido_if #(.CRED_W(4)) bus();
  controle_pedido dut (.clock(clock), .reset(reset), .bus(bus.slave));
  always #5 clock = ~clock;
  int m_c, m_brew, m_deliv, m_t, m_drink, m_price;
  int m_tv, m_troco, m_erro, m_ent, m_rst, m_ocup;
  function automatic int price_of(input int t);
    return t == 0 ? 2 : t == 1 ? 3 : t == 2 ? 4 : 0;
  endfunction
  function automatic int cap(input int s);
    return s > 15 ? 15 : s;
  endfunction
  task automatic model_reset();
    m_c = 0; m_brew = 0; m_deliv = 0; m_t = 0; m_drink = 0; m_price = 0;
    m_tv = 0; m_troco = 0; m_erro = 0; m_ent = 0; m_rst = 1; m_ocup = 0;
  endtask
  task automatic model_step(input int mv, input int mval, input int sv, input int st,
                            input int canc, input int pr);
    int v, e, p, s;
    v = mv ? (1 << mval) : 0;
    m_tv = 0; m_erro = 0; m_ent = 0;
    if (m_brew) begin
      if (v > 0) begin m_troco = v; m_tv = 1; m_erro = 1; end
      if (pr) begin
        m_brew = 0; m_deliv = 1; m_rst = 1;
      end else if (m_t == 15) begin
        m_troco = cap(m_c + m_price + v); m_tv = 1; m_erro = 1;
        m_c = 0; m_rst = 1; m_ocup = 0; m_brew = 0;
      end
      m_t++;
    end else if (m_deliv) begin
      s = m_c + v;
      m_troco = cap(s); m_tv = s > 0; m_ent = 1; m_c = 0; m_ocup = 0; m_deliv = 0;
    end else if (canc) begin
      s = m_c + v;
      m_troco = cap(s); m_tv = s > 0; m_c = 0;
    end else begin
      e = m_c;
      if (m_c + v <= 15) e = m_c + v;
      else begin m_troco = v; m_tv = 1; m_erro = 1; end
      if (sv) begin
        p = price_of(st);
        if (st == 3 || e < p) begin
          m_erro = 1; m_c = e;
        end else begin
          m_c = e - p; m_drink = st; m_price = p;
          m_brew = 1; m_t = 0; m_rst = 0; m_ocup = 1;
        end
      end else m_c = e;
    end
  endtask
  task automatic cyc(input int mv, input int mval, input int sv, input int st,
                     input int canc, input int pr);
    bus.moeda_valida = 1'(mv);
    bus.moeda_valor  = 2'(mval);
    bus.sel_valida   = 1'(sv);
    bus.sel_tipo     = 2'(st);
    bus.cancelar     = 1'(canc);
    bus.pronto       = 1'(pr);
    @(posedge clock);
    if (reset) model_reset();
    else model_step(mv, mval, sv, st, canc, pr);
    #1;
  endtask
  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus.credito, bus.troco_valido, bus.erro, bus.entregue, bus.tipo, bus.rst_cafeteira, bus.ocupado} !== 11'b0000_0_0_0_00_1_0) begin
      n_bad++;
      $display("FAIL reset_outputs got cred=%0d tv=%b erro=%b ent=%b tipo=%0d rstc=%b ocup=%b want 0 0 0 0 0 1 0",
               bus.credito, bus.troco_valido, bus.erro, bus.entregue, bus.tipo, bus.rst_cafeteira, bus.ocupado);
    end
  endtask
  task automatic test_pedido();
    do_reset();
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    n_cmp++;
    if (bus.credito !== 4'd4) begin n_bad++; $display("FAIL pedido_credit got %0d want 4", bus.credito); end
    cyc(0, 0, 1, 0, 0, 0);
    n_cmp++;
    if ({bus.credito, bus.tipo, bus.rst_cafeteira, bus.ocupado} !== {4'd2, 2'b00, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL pedido_accept got cred=%0d tipo=%0d rstc=%b ocup=%b want 2 0 0 1", bus.credito, bus.tipo, bus.rst_cafeteira, bus.ocupado);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.troco_valido, bus.troco, bus.entregue, bus.credito, bus.ocupado, bus.rst_cafeteira} !== {1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL pedido_change got tv=%b troco=%0d ent=%b cred=%0d ocup=%b rstc=%b want 1 2 1 0 0 1",
               bus.troco_valido, bus.troco, bus.entregue, bus.credito, bus.ocupado, bus.rst_cafeteira);
    end
  endtask
  task automatic test_rejeita();
    do_reset();
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 0, 0);
    n_cmp++;
    if ({bus.erro, bus.credito, bus.rst_cafeteira, bus.ocupado} !== {1'b1, 4'd1, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL rejeita_sel got erro=%b cred=%0d rstc=%b ocup=%b want 1 1 1 0", bus.erro, bus.credito, bus.rst_cafeteira, bus.ocupado);
    end
    cyc(0, 0, 1, 3, 0, 0);
    n_cmp++;
    if ({bus.erro, bus.credito, bus.ocupado} !== {1'b1, 4'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL rejeita_tipo11 got erro=%b cred=%0d ocup=%b want 1 1 0", bus.erro, bus.credito, bus.ocupado);
    end
    idle(1);
    n_cmp++;
    if (bus.erro !== 1'b0) begin n_bad++; $display("FAIL rejeita_pulse got erro=%b want 0", bus.erro); end
  endtask
  task automatic test_teto();
    do_reset();
    cyc(1, 3, 0, 0, 0, 0);
    cyc(1, 2, 0, 0, 0, 0);
    cyc(1, 3, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.troco_valido, bus.troco, bus.erro, bus.credito} !== {1'b1, 4'd8, 1'b1, 4'd12}) begin
      n_bad++;
      $display("FAIL teto_coin got tv=%b troco=%0d erro=%b cred=%0d want 1 8 1 12", bus.troco_valido, bus.troco, bus.erro, bus.credito);
    end
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.credito, bus.erro} !== {4'd15, 1'b0}) begin
      n_bad++;
      $display("FAIL teto_exact got cred=%0d erro=%b want 15 0", bus.credito, bus.erro);
    end
    cyc(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if ({bus.troco_valido, bus.troco, bus.credito} !== {1'b1, 4'd15, 4'd0}) begin
      n_bad++;
      $display("FAIL teto_cancel got tv=%b troco=%0d cred=%0d want 1 15 0", bus.troco_valido, bus.troco, bus.credito);
    end
    cyc(0, 0, 0, 0, 1, 0);
    n_cmp++;
    if (bus.troco_valido !== 1'b0) begin n_bad++; $display("FAIL cancel_empty got tv=%b want 0", bus.troco_valido); end
  endtask
  task automatic test_timeout();
    int early;
    do_reset();
    cyc(1, 2, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0);
    cyc(0, 0, 1, 2, 0, 0);
    early = 0;
    for (int i = 0; i < 15; i++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (bus.ocupado !== 1'b1 || bus.erro !== 1'b0 || bus.rst_cafeteira !== 1'b0 || bus.tipo !== 2'b10) early++;
    end
    n_cmp++;
    if (early != 0) begin n_bad++; $display("FAIL timeout_hold got %0d bad cycles want 0", early); end
    cyc(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.erro, bus.troco_valido, bus.troco, bus.credito, bus.rst_cafeteira, bus.ocupado} !== {1'b1, 1'b1, 4'd6, 4'd0, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_refund got erro=%b tv=%b troco=%0d cred=%0d rstc=%b ocup=%b want 1 1 6 0 1 0",
               bus.erro, bus.troco_valido, bus.troco, bus.credito, bus.rst_cafeteira, bus.ocupado);
    end
  endtask
  task automatic test_moeda_preparo();
    do_reset();
    cyc(1, 1, 0, 0, 0, 0);
    cyc(1, 1, 1, 2, 0, 0);
    n_cmp++;
    if ({bus.credito, bus.ocupado, bus.tipo, bus.erro} !== {4'd0, 1'b1, 2'b10, 1'b0}) begin
      n_bad++;
      $display("FAIL coin_sel_same got cred=%0d ocup=%b tipo=%0d erro=%b want 0 1 2 0", bus.credito, bus.ocupado, bus.tipo, bus.erro);
    end
    cyc(1, 3, 1, 0, 1, 0);
    n_cmp++;
    if ({bus.troco_valido, bus.troco, bus.erro, bus.credito, bus.ocupado} !== {1'b1, 4'd8, 1'b1, 4'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL coin_in_preparo got tv=%b troco=%0d erro=%b cred=%0d ocup=%b want 1 8 1 0 1",
               bus.troco_valido, bus.troco, bus.erro, bus.credito, bus.ocupado);
    end
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    n_cmp++;
    if ({bus.entregue, bus.troco_valido, bus.ocupado} !== {1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL deliver_nochange got ent=%b tv=%b ocup=%b want 1 0 0", bus.entregue, bus.troco_valido, bus.ocupado);
    end
  endtask
  task automatic test_reset_preparo();
    do_reset();
    cyc(1, 2, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    idle(3);
    do_reset();
    n_cmp++;
    if ({bus.credito, bus.troco_valido, bus.rst_cafeteira, bus.ocupado, bus.tipo, bus.entregue} !== {4'd0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_mid_preparo got cred=%0d tv=%b rstc=%b ocup=%b tipo=%0d ent=%b want 0 0 1 0 0 0",
               bus.credito, bus.troco_valido, bus.rst_cafeteira, bus.ocupado, bus.tipo, bus.entregue);
    end
  endtask
  task automatic test_aleatorio();
    logic [16:0] got, want;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0,
          $urandom_range(0, 3), $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0);
      got  = {bus.credito, bus.troco_valido, bus.troco_valido ? bus.troco : 4'd0, bus.erro,
              bus.entregue, bus.rst_cafeteira, bus.ocupado, bus.ocupado ? bus.tipo : 2'd0};
      want = {4'(m_c), 1'(m_tv), m_tv != 0 ? 4'(m_troco) : 4'd0, 1'(m_erro),
              1'(m_ent), 1'(m_rst), 1'(m_ocup), m_ocup != 0 ? 2'(m_drink) : 2'd0};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL random_cycle_%0d got %h want %h", i, got, want);
      end
    end
    reset = 1'b0;
  endtask
  initial begin
    bus.moeda_valida = 1'b0; bus.moeda_valor = 2'b00; bus.sel_valida = 1'b0;
    bus.sel_tipo = 2'b00; bus.cancelar = 1'b0; bus.pronto = 1'b0;
    model_reset();
    test_reset();
    test_pedido();
    test_rejeita();
    test_teto();
    test_timeout();
    test_moeda_preparo();
    test_reset_preparo();
    test_aleatorio();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
